// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module     : uart_tx_arbiter
// Description: Round-robin arbiter sharing one UART transmitter between
//              NUM_REQ byte sources, with start-handshake watchdog.
//              Optional grant lock for multi-byte messages: UART_ARB_LOCK_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CHAR_W    = 8,
    parameter int START_TMO = 64,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clock_50M,
    input  logic                      n_reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*CHAR_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        ack,
    output logic [CHAR_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      grant_valid,
    output logic                      tmo_err
);

    localparam int CNT_W = $clog2(START_TMO) + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t              r_state,       w_state;
    logic [NUM_REQ-1:0]  r_ack,         w_ack;
    logic [CHAR_W-1:0]   r_tx_data,     w_tx_data;
    logic                r_tx_start,    w_tx_start;
    logic [ID_W-1:0]     r_grant_id,    w_grant_id;
    logic                r_grant_valid, w_grant_valid;
    logic                r_tmo_err,     w_tmo_err;
    logic [ID_W-1:0]     r_ptr,         w_ptr;
    logic [CNT_W-1:0]    r_cnt,         w_cnt;

    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [ID_W-1:0]     w_next_ptr;
    int                  w_idx;

    // First asserted request at or above the pointer, wrapping to 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NUM_REQ)
                w_idx = w_idx - NUM_REQ;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(w_idx);
            end
        end
    end

    assign w_next_ptr = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

`ifndef UART_ARB_LOCK_EN
    logic unused_req_lock;
    assign unused_req_lock = ^req_lock;
`endif

    always_comb begin
        w_state       = r_state;
        w_ack         = '0;
        w_tx_start    = 1'b0;
        w_tmo_err     = 1'b0;
        w_tx_data     = r_tx_data;
        w_grant_id    = r_grant_id;
        w_grant_valid = r_grant_valid;
        w_ptr         = r_ptr;
        w_cnt         = r_cnt;
        case (r_state)
            S_IDLE: begin
                // A busy transmitter here belongs to someone else; hold off.
                if (w_found && !tx_busy) begin
                    w_tx_data     = req_data[int'(w_win)*CHAR_W +: CHAR_W];
                    w_grant_id    = w_win;
                    w_grant_valid = 1'b1;
                    w_ack         = NUM_REQ'(1) << w_win;
                    w_state       = S_LOAD;
                end
            end
            S_LOAD: begin
                w_tx_start = 1'b1;
                w_state    = S_START;
            end
            S_START: begin
                w_cnt   = '0;
                w_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state = S_WAIT_DONE;
                end else if (r_cnt == CNT_W'(START_TMO - 1)) begin
                    w_tmo_err     = 1'b1;
                    w_grant_valid = 1'b0;
                    w_ptr         = w_next_ptr;
                    w_state       = S_IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_grant_valid = 1'b0;
                    w_state       = S_IDLE;
`ifdef UART_ARB_LOCK_EN
                    // Holding the pointer on the winner re-grants it first.
                    if (req_lock[r_grant_id] && req[r_grant_id])
                        w_ptr = r_grant_id;
                    else
                        w_ptr = w_next_ptr;
`else
                    w_ptr = w_next_ptr;
`endif
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_50M or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= S_IDLE;
            r_ack         <= '0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_tmo_err     <= 1'b0;
            r_ptr         <= '0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state;
            r_ack         <= w_ack;
            r_tx_data     <= w_tx_data;
            r_tx_start    <= w_tx_start;
            r_grant_id    <= w_grant_id;
            r_grant_valid <= w_grant_valid;
            r_tmo_err     <= w_tmo_err;
            r_ptr         <= w_ptr;
            r_cnt         <= w_cnt;
        end
    end

    assign ack         = r_ack;
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign tmo_err     = r_tmo_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module     : tb_uart_tx_arbiter
// Description: Directed self-checking bench for uart_tx_arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        clock_50M;
    logic        n_reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        grant_valid;
    logic        tmo_err;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .CHAR_W    (8),
        .START_TMO (64)
    ) dut (
        .clock_50M   (clock_50M),
        .n_reset     (n_reset),
        .req         (req),
        .req_data    (req_data),
        .req_lock    (req_lock),
        .ack         (ack),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .tmo_err     (tmo_err)
    );

    initial clock_50M = 1'b0;
    always #5 clock_50M = ~clock_50M;

    // One complete granted frame: ack, start pulse, busy for busy_len cycles.
    task automatic frame(input int exp_id, input logic [7:0] exp_data,
                         input int busy_len, input bit drop);
        int n;
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << exp_id;
        n = 0;
        while (ack == 4'b0000 && n < 50) begin
            @(negedge clock_50M);
            n++;
        end
        checks++;
        if (ack !== exp_ack) begin
            errors++;
            $display("FAIL frame_ack: got %b expected %b", ack, exp_ack);
        end
        checks++;
        if (grant_id !== 2'(exp_id)) begin
            errors++;
            $display("FAIL frame_grant_id: got %0d expected %0d", grant_id, exp_id);
        end
        checks++;
        if (tx_data !== exp_data) begin
            errors++;
            $display("FAIL frame_tx_data: got %h expected %h", tx_data, exp_data);
        end
        checks++;
        if (grant_valid !== 1'b1 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL frame_load: got gv=%b start=%b expected gv=1 start=0", grant_valid, tx_start);
        end
        if (drop) req[exp_id] = 1'b0;
        @(negedge clock_50M);
        checks++;
        if (ack !== 4'b0000 || tx_start !== 1'b1) begin
            errors++;
            $display("FAIL frame_start: got ack=%b start=%b expected ack=0000 start=1", ack, tx_start);
        end
        @(negedge clock_50M);
        checks++;
        if (tx_start !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_pulse: got %b expected 0", tx_start);
        end
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clock_50M);
        tx_busy = 1'b0;
        checks++;
        if (grant_valid !== 1'b1 || tx_data !== exp_data || ack !== 4'b0000) begin
            errors++;
            $display("FAIL frame_hold: got gv=%b data=%h ack=%b expected gv=1 data=%h ack=0000",
                     grant_valid, tx_data, ack, exp_data);
        end
        n = 0;
        while (grant_valid === 1'b1 && n < 10) begin
            @(negedge clock_50M);
            n++;
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL frame_release: got %0d cycles expected 1", n);
        end
    endtask

    task automatic test_reset();
        int n;
        n_reset  = 1'b0;
        req      = 4'b0000;
        req_lock = 4'b0000;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        tx_busy  = 1'b0;
        #12;
        checks++;
        if (ack !== 4'b0 || tx_data !== 8'h00 || tx_start !== 1'b0 ||
            grant_id !== 2'd0 || grant_valid !== 1'b0 || tmo_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b data=%h start=%b id=%0d gv=%b tmo=%b expected all 0",
                     ack, tx_data, tx_start, grant_id, grant_valid, tmo_err);
        end
        @(negedge clock_50M);
        n_reset = 1'b1;
        // Start a frame for requester 1 and reset it while the transmitter is busy.
        req = 4'b0010;
        n = 0;
        while (ack == 4'b0000 && n < 20) begin
            @(negedge clock_50M);
            n++;
        end
        checks++;
        if (ack !== 4'b0010 || tx_data !== 8'h22) begin
            errors++;
            $display("FAIL reset_pre_ack: got ack=%b data=%h expected 0010 22", ack, tx_data);
        end
        req = 4'b0000;
        @(negedge clock_50M);
        @(negedge clock_50M);
        tx_busy = 1'b1;
        @(negedge clock_50M);
        @(negedge clock_50M);
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL reset_pre_done: got gv=%b id=%0d expected 1 1", grant_valid, grant_id);
        end
        #2 n_reset = 1'b0;
        #1;
        checks++;
        if (ack !== 4'b0 || tx_data !== 8'h00 || tx_start !== 1'b0 ||
            grant_id !== 2'd0 || grant_valid !== 1'b0 || tmo_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: got ack=%b data=%h start=%b id=%0d gv=%b tmo=%b expected all 0",
                     ack, tx_data, tx_start, grant_id, grant_valid, tmo_err);
        end
        tx_busy = 1'b0;
        @(negedge clock_50M);
        n_reset = 1'b1;
        repeat (3) @(negedge clock_50M);
        checks++;
        if (ack !== 4'b0000 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_reack: got ack=%b gv=%b expected 0000 0", ack, grant_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_data [5];
        int         exp_id   [5];
        exp_id   = '{0, 1, 2, 3, 0};
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        req = 4'b1111;
        for (int k = 0; k < 5; k++)
            frame(exp_id[k], exp_data[k], 3, 1'b0);
        req = 4'b0000;
    endtask

    task automatic test_single();
        req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        req      = 4'b0100;
        frame(2, 8'hA5, 10, 1'b1);
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    endtask

    task automatic test_timeout();
        int n;
        req = 4'b1001;
        n = 0;
        while (ack == 4'b0000 && n < 20) begin
            @(negedge clock_50M);
            n++;
        end
        checks++;
        if (ack !== 4'b1000) begin
            errors++;
            $display("FAIL tmo_ack: got %b expected 1000", ack);
        end
        req[3] = 1'b0;
        @(negedge clock_50M);
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL tmo_start: got %b expected 1", tx_start);
        end
        // START occupies one cycle, then 64 watchdog cycles.
        n = 0;
        while (tmo_err !== 1'b1 && n < 100) begin
            @(negedge clock_50M);
            n++;
        end
        checks++;
        if (n !== 65) begin
            errors++;
            $display("FAIL tmo_latency: got %0d cycles expected 65", n);
        end
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_release: got gv=%b expected 0", grant_valid);
        end
        @(negedge clock_50M);
        checks++;
        if (tmo_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse: got %b expected 0", tmo_err);
        end
        frame(0, 8'h11, 3, 1'b1);
    endtask

    task automatic test_busy_in_idle();
        tx_busy = 1'b1;
        req     = 4'b0001;
        repeat (5) @(negedge clock_50M);
        checks++;
        if (ack !== 4'b0000 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle_hold: got ack=%b gv=%b expected 0000 0", ack, grant_valid);
        end
        tx_busy = 1'b0;
        @(negedge clock_50M);
        checks++;
        if (ack !== 4'b0001) begin
            errors++;
            $display("FAIL busy_idle_ack: got %b expected 0001", ack);
        end
        frame(0, 8'h11, 3, 1'b1);
    endtask

    task automatic test_lock();
        int exp_id [4];
        int n1;
`ifdef UART_ARB_LOCK_EN
        exp_id = '{1, 1, 1, 0};
`else
        exp_id = '{1, 0, 1, 0};
`endif
        n1       = 0;
        req      = 4'b0011;
        req_lock = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            frame(exp_id[k], (exp_id[k] == 1) ? 8'h22 : 8'h11, 3,
                  (exp_id[k] == 1 && n1 == 2));
            if (exp_id[k] == 1) n1++;
        end
        req      = 4'b0000;
        req_lock = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_busy_in_idle();
        test_lock();
        repeat (2) @(negedge clock_50M);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
